// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: req/ack bus access, stall, write-back registers
// Word/byte loads and stores with a bounded wait, misalignment and timeout error pulses.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic [31:0] mem_data,
  input  logic        if_mem_read,
  input  logic        if_mem_write,
  input  logic        load_byte,
  input  logic        if_reg_write_i,
  input  logic [4:0]  data_write_reg_i,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_reg_write,
  output logic [31:0] fwd_data,
  output logic        fwd_valid,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] C_MAX = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_byte;
  logic [1:0]    r_lane;
  logic [4:0]    r_dst;
  logic          r_rw;

  logic          w_mem_op;
  logic          w_mis;
  logic          w_last;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;

  assign w_mem_op = if_mem_read | if_mem_write;
  assign w_mis    = w_mem_op & ~load_byte & (result[1:0] != 2'b00);
  assign w_last   = (r_cnt == C_MAX);
  assign w_shift  = bus_rdata >> {r_lane, 3'b000};
  assign w_load   = r_byte ? {{24{w_shift[7]}}, w_shift[7:0]} : bus_rdata;

  // The timeout cycle releases the stall so upstream can advance alongside the abort.
  assign mem_stall = ~rst & ((r_state == IDLE) ? (w_mem_op & ~w_mis) : (~bus_ack & ~w_last));

  assign fwd_data  = wb_data;
  assign fwd_valid = wb_reg_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_byte       <= 1'b0;
      r_lane       <= 2'b00;
      r_dst        <= 5'd0;
      r_rw         <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'd0;
      bus_wdata    <= 32'd0;
      wb_data      <= 32'd0;
      wb_reg       <= 5'd0;
      wb_reg_write <= 1'b0;
      addr_err     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_mem_op) begin
            wb_data      <= result;
            wb_reg       <= data_write_reg_i;
            wb_reg_write <= if_reg_write_i;
          end else if (w_mis) begin
            addr_err     <= 1'b1;
            wb_reg_write <= 1'b0;
          end else begin
            bus_req      <= 1'b1;
            bus_we       <= if_mem_write;
            bus_addr     <= {result[31:2], 2'b00};
            bus_be       <= load_byte ? (4'b0001 << result[1:0]) : 4'hF;
            bus_wdata    <= load_byte ? {4{mem_data[7:0]}} : mem_data;
            r_byte       <= load_byte;
            r_lane       <= result[1:0];
            r_dst        <= data_write_reg_i;
            r_rw         <= if_reg_write_i;
            r_cnt        <= '0;
            wb_reg_write <= 1'b0;
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            r_state <= IDLE;
            wb_reg  <= r_dst;
            if (!bus_we) begin
              wb_data      <= w_load;
              wb_reg_write <= r_rw;
            end else begin
              wb_reg_write <= 1'b0;
            end
          end else if (w_last) begin
            bus_req      <= 1'b0;
            bus_err      <= 1'b1;
            wb_reg_write <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result, mem_data;
  logic        if_mem_read, if_mem_write, load_byte, if_reg_write_i;
  logic [4:0]  data_write_reg_i;
  logic        mem_stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] wb_data, fwd_data;
  logic [4:0]  wb_reg;
  logic        wb_reg_write, fwd_valid, addr_err, bus_err;

  int checks = 0;
  int failures = 0;
  int stall_cnt;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .result(result), .mem_data(mem_data),
    .if_mem_read(if_mem_read), .if_mem_write(if_mem_write), .load_byte(load_byte),
    .if_reg_write_i(if_reg_write_i), .data_write_reg_i(data_write_reg_i),
    .mem_stall(mem_stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_data(wb_data), .wb_reg(wb_reg), .wb_reg_write(wb_reg_write),
    .fwd_data(fwd_data), .fwd_valid(fwd_valid), .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, input logic by, input logic rw, input logic [4:0] rg);
    result = a; mem_data = d; if_mem_read = rd; if_mem_write = wr;
    load_byte = by; if_reg_write_i = rw; data_write_reg_i = rg;
  endtask

  task automatic clr_op();
    set_op(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
    clr_op();
    samp();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
    tick();
    rst = 1'b0;

    // ALU pass-through
    set_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    samp(); chk("alu_stall", 32'(mem_stall), 32'd0);
    tick(); clr_op();
    samp();
    chk("alu_wb_data", wb_data, 32'h1234_5678);
    chk("alu_wb_reg", 32'(wb_reg), 32'd5);
    chk("alu_wb_rw", 32'(wb_reg_write), 32'd1);
    chk("alu_fwd", fwd_data, 32'h1234_5678);
    tick();

    // LW, ack in first bus_req cycle
    set_op(32'h0000_0100, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7);
    samp(); chk("lw_stall0", 32'(mem_stall), 32'd1);
    tick(); bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    samp();
    chk("lw_req", 32'(bus_req), 32'd1);
    chk("lw_addr", bus_addr, 32'h100);
    chk("lw_be", 32'(bus_be), 32'hF);
    chk("lw_we", 32'(bus_we), 32'd0);
    chk("lw_stall1", 32'(mem_stall), 32'd0);
    tick(); bus_ack = 1'b0; clr_op();
    samp();
    chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("lw_wb_reg", 32'(wb_reg), 32'd7);
    chk("lw_wb_rw", 32'(wb_reg_write), 32'd1);
    chk("lw_req_drop", 32'(bus_req), 32'd0);
    tick();

    // LB lane 3, negative byte
    set_op(32'h0000_0203, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    tick(); bus_ack = 1'b1; bus_rdata = 32'h80AA_BBCC;
    samp();
    chk("lb3_addr", bus_addr, 32'h200);
    chk("lb3_be", 32'(bus_be), 32'h8);
    tick(); bus_ack = 1'b0; clr_op();
    samp(); chk("lb3_wb_data", wb_data, 32'hFFFF_FF80);
    tick();

    // LB lane 1, positive byte
    set_op(32'h0000_0201, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    tick(); bus_ack = 1'b1; bus_rdata = 32'h0000_7F00;
    samp(); chk("lb1_be", 32'(bus_be), 32'h2);
    tick(); bus_ack = 1'b0; clr_op();
    samp(); chk("lb1_wb_data", wb_data, 32'h0000_007F);
    tick();

    // SB, ack on 4th bus_req cycle
    set_op(32'h0000_0302, 32'h0000_00A5, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3);
    stall_cnt = 0;
    samp(); if (mem_stall) stall_cnt++;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) bus_ack = 1'b1;
      samp();
      if (mem_stall) stall_cnt++;
      chk($sformatf("sb_req_c%0d", c), 32'(bus_req), 32'd1);
      chk($sformatf("sb_we_c%0d", c), 32'(bus_we), 32'd1);
      chk($sformatf("sb_be_c%0d", c), 32'(bus_be), 32'h4);
      chk($sformatf("sb_wdata_c%0d", c), bus_wdata, 32'hA5A5_A5A5);
    end
    chk("sb_stall_cycles", 32'(stall_cnt), 32'd4);
    tick(); bus_ack = 1'b0; clr_op();
    samp();
    chk("sb_req_drop", 32'(bus_req), 32'd0);
    chk("sb_wb_rw", 32'(wb_reg_write), 32'd0);
    tick();

    // Timeout with no ack
    set_op(32'h0000_0400, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4);
    for (int c = 1; c <= 4; c++) begin
      tick(); samp();
      chk($sformatf("to_req_c%0d", c), 32'(bus_req), 32'd1);
      chk($sformatf("to_stall_c%0d", c), 32'(mem_stall), (c == 4) ? 32'd0 : 32'd1);
      chk($sformatf("to_err_c%0d", c), 32'(bus_err), 32'd0);
    end
    tick(); clr_op();
    samp();
    chk("to_req_drop", 32'(bus_req), 32'd0);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("to_no_addr_err", 32'(addr_err), 32'd0);
    tick(); samp();
    chk("to_err_pulse", 32'(bus_err), 32'd0);

    // Ack on the timeout cycle wins
    tick();
    set_op(32'h0000_0404, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin bus_ack = 1'b1; bus_rdata = 32'h1122_3344; end
    end
    tick(); bus_ack = 1'b0; clr_op();
    samp();
    chk("toack_bus_err", 32'(bus_err), 32'd0);
    chk("toack_wb_data", wb_data, 32'h1122_3344);
    chk("toack_wb_rw", 32'(wb_reg_write), 32'd1);
    tick();

    // Misaligned word load
    set_op(32'h0000_0102, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2);
    samp(); chk("mis_stall", 32'(mem_stall), 32'd0);
    tick(); clr_op();
    samp();
    chk("mis_req", 32'(bus_req), 32'd0);
    chk("mis_addr_err", 32'(addr_err), 32'd1);
    chk("mis_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("mis_no_bus_err", 32'(bus_err), 32'd0);
    tick(); samp();
    chk("mis_err_pulse", 32'(addr_err), 32'd0);

    // Reset while waiting
    tick();
    set_op(32'h0000_0500, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
    tick(); samp();
    chk("rstw_req_before", 32'(bus_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_req", 32'(bus_req), 32'd0);
    chk("rstw_stall", 32'(mem_stall), 32'd0);
    chk("rstw_addr", bus_addr, 32'd0);
    chk("rstw_wdata", bus_wdata, 32'd0);
    chk("rstw_wb_data", wb_data, 32'd0);
    tick(); clr_op(); rst = 1'b0;
    samp();
    chk("rstw_req_after", 32'(bus_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage placed directly downstream of the EX stage. It consumes the EX outputs (ALU result/address, store data, load/store controls, destination register) and performs word or byte accesses on a single-master req/ack data bus. It stalls the upstream pipeline while a bus transaction is outstanding and registers load data or ALU results into the write-back interface.

## Interface
- TIMEOUT, 16: maximum cycles `bus_req` is held without `bus_ack` before the access is aborted (≥2).
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- result  in  32  ALU result; this is the byte address for loads and stores.
- mem_data  in  32  store data (rt value).
- if_mem_read  in  1  load request; already zeroed by EX when bubbled.
- if_mem_write  in  1  store request; already zeroed by EX when bubbled.
- load_byte  in  1  1 = byte access (LB/SB), 0 = word access (LW/SW).
- if_reg_write_i  in  1  instruction writes a register.
- data_write_reg_i  in  5  destination register.
- mem_stall  out  1  hold EX/MEM inputs stable and freeze upstream stages.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, `{result[31:2],2'b00}`.
- bus_be  out  4  byte enables; bit n covers `wdata[8n+7:8n]`.
- bus_wdata  out  32  write data.
- bus_ack  in  1  single-cycle completion; `bus_rdata` is valid in the same cycle.
- bus_rdata  in  32  read data.
- wb_data  out  32  registered write-back value.
- wb_reg  out  5  registered destination register.
- wb_reg_write  out  1  registered write enable.
- fwd_data  out  32  same as `wb_data`; the forwarding tap for ID/EX.
- fwd_valid  out  1  equals `wb_reg_write`.
- addr_err  out  1  one-cycle pulse on a misaligned word access.
- bus_err  out  1  one-cycle pulse on a timeout.

## Operation
- States are IDLE and WAIT. Reset puts the block in IDLE, with every registered output at 0 and `mem_stall` at 0 while `rst` is high.
- IDLE, no memory op (`if_mem_read|if_mem_write` = 0):
  - At the edge: `wb_data<=result`, `wb_reg<=data_write_reg_i`, `wb_reg_write<=if_reg_write_i`.
  - `mem_stall` = 0.
- IDLE, word op with `result[1:0]≠0`:
  - No bus access is issued.
  - `addr_err` pulses on the next cycle.
  - `wb_reg_write<=0`.
  - No stall.
- IDLE, valid memory op:
  - `mem_stall` = 1 combinationally.
  - At the edge, latch the address, `we`, byte mode, lane (`result[1:0]`), destination, and `reg_write`.
  - Drive `bus_req<=1`, set `bus_we`/`bus_addr`/`bus_be`/`bus_wdata`, clear the timeout counter, and go to WAIT.
- Byte enables and write data:
  - Word access: `bus_be`=4'hF, `bus_wdata`=`mem_data`.
  - Byte access: `bus_be`=`4'b0001<<lane`, `bus_wdata`=`{4{mem_data[7:0]}}`.
- WAIT:
  - `mem_stall` = `~bus_ack`.
  - Bus outputs are held stable until ack.
  - On `bus_ack`:
    - `bus_req<=0`, state→IDLE.
    - Load: `wb_data<=` the word, or for a byte load the selected byte `bus_rdata[8·lane+7:8·lane]` sign-extended.
    - `wb_reg_write<=` latched `reg_write`.
    - Store: `wb_reg_write<=0`.
  - No ack, counter = TIMEOUT−1: `bus_req<=0`, `bus_err` pulses, `wb_reg_write<=0`, state→IDLE, `mem_stall` = 0 this cycle.
  - Ack in the same cycle as the timeout: ack wins and no error is raised.
  - Counter width is `$clog2(TIMEOUT)`. It is not incremented past TIMEOUT−1.
- While `mem_stall` = 1, the inputs are held by upstream and are not re-sampled.
- `rst` asserted mid-WAIT: `bus_req` drops immediately (async) and the transaction is discarded.

## Timing
- Non-memory ops: latency 1. The value appears on `wb_*` the cycle after it is presented.
- Memory ops:
  - Cycle 0: present the op; `mem_stall`=1.
  - Cycle 1: `bus_req`=1.
  - Ack in cycle k≥1: `wb_*` is updated at the end of cycle k, and `mem_stall`=0 in cycle k.
  - Minimum latency is 2 cycles.
- Back-to-back memory ops:
  - `bus_req` is low for at least one cycle between transactions (the IDLE capture cycle).
  - Throughput is at most one access per 2 cycles.
- `addr_err` and `bus_err` are registered single-cycle pulses, never asserted together.

## Test plan
- ALU pass-through: `result`=0x1234_5678, `reg`=5, `reg_write`=1, no mem op → next cycle `wb_data`=0x1234_5678, `wb_reg`=5, `wb_reg_write`=1, `mem_stall` never 1.
- LW with immediate ack: `addr`=0x100, ack 1 cycle after `bus_req`, `rdata`=0xDEAD_BEEF → `bus_addr`=0x100, `be`=F, `we`=0; `wb_data`=0xDEAD_BEEF; stall for exactly 1 cycle.
- LB lane 3 sign-extend: `addr`=0x203, `rdata`=0x80AA_BBCC → `bus_addr`=0x200, `wb_data`=0xFFFF_FF80. Lane 1 with `rdata`=0x0000_7F00 → 0x0000_007F.
- SB with delayed ack (4 cycles): `addr`=0x302, `mem_data`=0x0000_00A5 → `be`=4'b0100, `wdata`=0xA5A5_A5A5, `we`=1 held for 4 cycles, stall lasts 4 cycles, `wb_reg_write`=0.
- Timeout, TIMEOUT=4, no ack → `bus_req` high for 4 cycles then drops, `bus_err` pulses once, `wb_reg_write`=0, next op accepted. Repeat with ack on the 4th cycle → no `bus_err`, data written back.
- Misaligned LW at 0x102 → no `bus_req`, `addr_err` pulse, `wb_reg_write`=0. Assert `rst` in WAIT → `bus_req`=0 immediately, all outputs 0.
